vpu_tile_accumulator: RTL
=========================

Name: vpu_tile_accumulator

Overview:
- Sits directly downstream of the VPU controller and tile datapath.
- Consumes the element stream emitted while `store` is high: one partial-product tile per compute pass.
- Accumulates K_TILES partial tiles (the COL_N/COL_A reduction) into a local tile buffer, then drains the finished output tile row-major over a valid/ready handshake toward output memory.

Parameters:
- ACC_W, 32, signed accumulator/element width
- ROW_A, 4, tile rows
- COL_A, 4, tile columns
- COL_N, 16, full reduction dimension; K_TILES = COL_N/COL_A (default 4)
- TILE_ELEMS, ROW_A*COL_A (derived, 16), elements per tile

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- store  input  1  element-valid strobe from controller; one element per high cycle
- store_data  input  ACC_W  signed partial-product element, row-major within tile
- reset_sys  input  1  synchronous abort: discard buffer, return to ACCUM with counters zero
- store_ready  output  1  high when an element can be accepted
- out_valid  output  1  drained element valid
- out_data  output  ACC_W  accumulated element
- out_last  output  1  high with final element (index TILE_ELEMS-1) of a drained tile
- out_ready  input  1  downstream accept
- sat_flag  output  1  sticky: some accumulation saturated since last reset/reset_sys
- ovf_err  output  1  sticky: `store` seen while store_ready low (element dropped)
- busy  output  1  high in DRAIN

Behaviour:
- Reset is asynchronous and active-low. While `reset` is low:
  - state = ACCUM; elem_cnt = 0; k_cnt = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
  - sat_flag = 0, ovf_err = 0, busy = 0; store_ready = 1.
  - Buffer contents are don't-care.
- States: ACCUM, DRAIN.
- ACCUM:
  - store_ready = 1. Each cycle with `store`=1 takes one element at index elem_cnt.
  - If k_cnt==0: buf[elem_cnt] <= store_data (overwrite, no clear pass needed).
  - Otherwise: buf[elem_cnt] <= sat(buf[elem_cnt] + store_data).
  - sat(): signed add at ACC_W+1 bits, clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sat_flag.
  - elem_cnt wraps TILE_ELEMS-1 -> 0 and increments k_cnt.
  - On the element that completes k_cnt==K_TILES-1: k_cnt -> 0, state -> DRAIN next cycle.
- DRAIN:
  - store_ready = 0 and busy = 1.
  - Drain index rd_cnt starts at 0. out_valid is registered and first goes high one cycle after DRAIN entry.
  - Handshake: the transfer occurs when out_valid && out_ready. out_data and out_valid must hold stable while out_ready is low.
  - out_last = (rd_cnt == TILE_ELEMS-1).
  - After the last transfer: out_valid -> 0, state -> ACCUM, store_ready = 1 the following cycle.
  - Sustained out_ready = 1 gives one element per cycle, i.e. TILE_ELEMS transfers in TILE_ELEMS consecutive cycles.
- `store` in DRAIN: element dropped, buffer untouched, ovf_err set (sticky).
- reset_sys (synchronous, overrides all):
  - state -> ACCUM; elem_cnt, k_cnt, rd_cnt -> 0; out_valid -> 0.
  - sat_flag and ovf_err are cleared.
  - A `store` in the same cycle is ignored.
- The buffer is a register array (or a single-port RAM behind a sub-module). Read-modify-write completes within one cycle, so back-to-back `store` at full rate is supported.
- K_TILES==1 is legal: every tile goes straight to DRAIN with no accumulation.

Decomposition:
- Shared package/header (config_sys.vh): ROW_A, COL_A, COL_N, ACC_W, and derived K_TILES and TILE_ELEMS.
- Derived counter widths are computed with $clog2 of TILE_ELEMS and K_TILES.
- One natural sub-module, `sat_add`: combinational signed saturating adder with an overflow output, reused by other VPU accumulate paths.

Test Plan:
- Reset low mid-DRAIN (rd_cnt=5) -> out_valid=0 and store_ready=1 immediately. After release, a 4-tile group of all-1 elements drains 16 elements of value 4.
- Four tiles with element i = i, out_ready tied high -> 16 consecutive transfers with out_data = 4*i; out_last only on i=15; store_ready returns one cycle after the last transfer.
- Tiles of 0x7FFFFFF0, +0x10, +0x10, 0 at element 0 -> out_data[0] = 0x7FFFFFFF and sat_flag = 1. Negative mirror (0x80000010, -0x10, -0x10, 0) -> 0x80000000.
- DRAIN with out_ready toggling 1,0,0,1,... -> out_data stable during stalls, no element skipped or duplicated, exactly 16 transfers.
- `store` pulsed during DRAIN with data 99 -> ovf_err = 1 and drained values unchanged.
- reset_sys asserted after 2.5 tiles -> sat_flag and ovf_err clear; the next full 4-tile group of value 2 drains all 8s, with no residue from the aborted group.

Source files
------------

// File: rtl/vpu_tile_accumulator_pkg.sv
// vpu_tile_accumulator_pkg
//   Shared configuration for the VPU tile accumulator: tile geometry,
//   accumulator width, derived reduction depth and counter widths, and
//   the FSM state encoding.
//   No ports.

package vpu_tile_accumulator_pkg;

   localparam int ACC_W      = 32;
   localparam int ROW_A      = 4;
   localparam int COL_A      = 4;
   localparam int COL_N      = 16;

   localparam int K_TILES    = COL_N / COL_A;
   localparam int TILE_ELEMS = ROW_A * COL_A;

   // Keep counters at least one bit wide so K_TILES==1 or a 1-element
   // tile still elaborates.
   localparam int ELEM_W     = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
   localparam int K_W        = (K_TILES > 1) ? $clog2(K_TILES) : 1;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [ELEM_W-1:0]       elem_idx_t;
   typedef logic [K_W-1:0]          k_idx_t;

   localparam elem_idx_t ELEM_LAST = elem_idx_t'(TILE_ELEMS - 1);
   localparam k_idx_t    K_LAST    = k_idx_t'(K_TILES - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/vpu_tile_accumulator_if.sv
// vpu_tile_accumulator_if
//   Element-in / tile-out stream bundle for the tile accumulator.
//   store, store_data, store_ready : partial-product element stream in
//   out_valid, out_data, out_last  : drained output tile, row-major
//   out_ready                      : downstream accept
//   Modports: slave = accumulator side, master = controller/memory side.

interface vpu_tile_accumulator_if;
   import vpu_tile_accumulator_pkg::*;

   logic store;
   acc_t store_data;
   logic store_ready;
   logic out_valid;
   acc_t out_data;
   logic out_last;
   logic out_ready;

   modport slave (
      input  store, store_data, out_ready,
      output store_ready, out_valid, out_data, out_last
   );

   modport master (
      output store, store_data, out_ready,
      input  store_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/vpu_tile_accumulator_sat_add.sv
// sat_add
//   Combinational signed saturating adder. The sum is formed one bit wider
//   than the operands and clamped to the signed W-bit range.
//   a, b : signed operands
//   sum  : clamped result
//   ovf  : high when the result was clamped

module sat_add #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                ovf
);

   logic [W:0] wide;

   always_comb begin
      wide = {a[W-1], a} + {b[W-1], b};
      // Top two bits disagree only when the true result left the W-bit range.
      ovf  = wide[W] ^ wide[W-1];
      if (!ovf)
         sum = wide[W-1:0];
      else if (wide[W])
         sum = {1'b1, {(W-1){1'b0}}};
      else
         sum = {1'b0, {(W-1){1'b1}}};
   end

endmodule

// File: rtl/vpu_tile_accumulator.sv
// vpu_tile_accumulator
//   Accumulates K_TILES partial-product tiles into a local tile buffer and
//   drains the finished tile row-major over a valid/ready handshake.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   reset_sys : synchronous abort, back to ACCUM with counters and flags clear
//   io        : element stream in / drained tile out (slave modport)
//   sat_flag  : sticky, an accumulation clamped
//   ovf_err   : sticky, an element arrived while store_ready was low
//   busy      : high while draining
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACCUM | taking elements; first tile overwrites, later tiles add
//   DRAIN | presenting buffer elements rd_cnt = 0..TILE_ELEMS-1

module vpu_tile_accumulator
   import vpu_tile_accumulator_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reset_sys,
   vpu_tile_accumulator_if.slave   io,
   output logic                    sat_flag,
   output logic                    ovf_err,
   output logic                    busy
);

   state_t    state;
   elem_idx_t elem_cnt;
   elem_idx_t rd_cnt;
   elem_idx_t rd_nxt;
   k_idx_t    k_cnt;

   acc_t      tile_buf [TILE_ELEMS];
   acc_t      sum;
   logic      sum_ovf;

   logic      store_ready_q;
   logic      out_valid_q;
   logic      out_last_q;
   acc_t      out_data_q;

   logic      take;
   logic      drop;

   // store_ready_q is high exactly in ACCUM, so it doubles as the accept gate.
   assign take   = io.store && store_ready_q && !reset_sys;
   assign drop   = io.store && !store_ready_q;
   assign rd_nxt = rd_cnt + 1'b1;

   sat_add #(.W(ACC_W)) u_sat_add (
      .a   (tile_buf[elem_cnt]),
      .b   (io.store_data),
      .sum (sum),
      .ovf (sum_ovf)
   );

   // The first tile of a group overwrites, so no clear pass is needed.
   always_ff @(posedge clk) begin
      if (take)
         tile_buf[elem_cnt] <= (k_cnt == '0) ? io.store_data : sum;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ACCUM;
         elem_cnt      <= '0;
         k_cnt         <= '0;
         rd_cnt        <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         store_ready_q <= 1'b1;
         sat_flag      <= 1'b0;
         ovf_err       <= 1'b0;
         busy          <= 1'b0;
      end else if (reset_sys) begin
         state         <= ACCUM;
         elem_cnt      <= '0;
         k_cnt         <= '0;
         rd_cnt        <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         store_ready_q <= 1'b1;
         sat_flag      <= 1'b0;
         ovf_err       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (drop)
            ovf_err <= 1'b1;

         case (state)
            ACCUM: begin
               if (take) begin
                  if (k_cnt != '0 && sum_ovf)
                     sat_flag <= 1'b1;
                  if (elem_cnt == ELEM_LAST) begin
                     elem_cnt <= '0;
                     if (k_cnt == K_LAST) begin
                        k_cnt         <= '0;
                        rd_cnt        <= '0;
                        state         <= DRAIN;
                        store_ready_q <= 1'b0;
                        busy          <= 1'b1;
                     end else begin
                        k_cnt <= k_cnt + 1'b1;
                     end
                  end else begin
                     elem_cnt <= elem_cnt + 1'b1;
                  end
               end
            end

            DRAIN: begin
               // out_valid is low in DRAIN only on the entry cycle.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= tile_buf[rd_cnt];
                  out_last_q  <= (rd_cnt == ELEM_LAST);
               end else if (io.out_ready) begin
                  if (rd_cnt == ELEM_LAST) begin
                     out_valid_q   <= 1'b0;
                     out_last_q    <= 1'b0;
                     rd_cnt        <= '0;
                     state         <= ACCUM;
                     store_ready_q <= 1'b1;
                     busy          <= 1'b0;
                  end else begin
                     rd_cnt     <= rd_nxt;
                     out_data_q <= tile_buf[rd_nxt];
                     out_last_q <= (rd_nxt == ELEM_LAST);
                  end
               end
            end

            default: state <= ACCUM;
         endcase
      end
   end

   assign io.store_ready = store_ready_q;
   assign io.out_valid   = out_valid_q;
   assign io.out_data    = out_data_q;
   assign io.out_last    = out_last_q;

endmodule
